fetch_controller: RTL and testbench
===================================

FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0, is the PC loaded at reset.
REQ-002 Parameter LAST_ADDR, default 32'h1C, is the highest valid instruction byte address.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  is the asynchronous, active-high reset.
REQ-005 Port start  input  1  is a one-cycle pulse that leaves IDLE.
REQ-006 Port imem_addr  output  32  is the byte address driven to the combinational instruction memory.
REQ-007 Port imem_data  input  32  is the instruction word returned in the same cycle.
REQ-008 Port inst_out  output  32  is the registered instruction presented to decode.
REQ-009 Port pc_out  output  32  is the address of inst_out.
REQ-010 Port inst_valid  output  1  means inst_out/pc_out hold a valid instruction.
REQ-011 Port inst_ready  input  1  means decode accepts inst_out this cycle.
REQ-012 Port branch_en  input  1  is a one-cycle redirect request.
REQ-013 Port branch_target  output-side input  32  is the redirect byte address, sampled when branch_en=1.
REQ-014 Port halted  output  1  is high in HALT.
REQ-015 Port fault  output  1  is high in FAULT.
REQ-016 Port fetch_count  output  16  is the number of accepted instructions.

Function
REQ-017 The controller SHALL implement states IDLE, RUN, HALT and FAULT, held in an internal state register.
REQ-018 imem_addr SHALL equal the internal PC register combinationally at all times.
REQ-019 Output slot free = (inst_valid==0) or (inst_valid and inst_ready).
- Accepted = inst_valid and inst_ready.
REQ-020 IDLE: no fetch; start=1 -> RUN next cycle, with the PC unchanged.
REQ-021 RUN fetch, when the slot is free, PC<=LAST_ADDR, and imem_data!=0:
- inst_out<=imem_data, pc_out<=PC, inst_valid<=1, PC<=PC+4 (mod 2^32); latency 1 cycle from address to inst_valid.
REQ-022 RUN, slot not free: PC, inst_out, pc_out and inst_valid SHALL hold (stall).
REQ-023 RUN, slot free, imem_data==32'h0: -> HALT.
- Zero word is not presented; inst_valid<=0; PC holds at the zero-word address.
REQ-024 RUN, slot free, PC>LAST_ADDR: -> HALT with inst_valid<=0, and the memory is not read.
REQ-025 In HALT, an already-valid instruction accepted in the transition cycle SHALL count; no new fetches SHALL occur.
REQ-026 branch_en=1 with branch_target[1:0]==0, in RUN or HALT:
- PC<=branch_target, inst_valid<=0 (flush), state<=RUN; the fetch from the target occurs the following cycle.
- Branch has priority over fetch, stall and halt detection in the same cycle.
REQ-027 branch_en=1 with branch_target[1:0]!=0 in RUN or HALT: -> FAULT, with inst_valid<=0 and the PC unchanged.
REQ-028 FAULT SHALL be exited only by rst; branch_en and start are ignored in FAULT and IDLE.
REQ-029 A branch in the same cycle as an acceptance SHALL still increment fetch_count for the accepted instruction.
REQ-030 fetch_count SHALL increment by 1 per accepted instruction and saturate at 16'hFFFF.

Reset
REQ-031 rst=1 SHALL asynchronously force the following, regardless of clk:
- state=IDLE, PC=RESET_PC, inst_out=0, pc_out=0, inst_valid=0, halted=0, fault=0, fetch_count=0.
REQ-032 Reset asserted mid-stall or mid-branch SHALL discard the pending instruction; after release, behaviour is identical to a power-on reset.

Verification
REQ-033 Memory 0x0=15, 0x4=61, 0x8=23, 0xC=81, 0x10=0; rst, start, inst_ready=1:
- inst_out sequence 15,61,23,81 with pc_out 0,4,8,C on consecutive cycles.
- halted=1 with PC=0x10, fetch_count=4.
REQ-034 Same memory, inst_ready=0 for 3 cycles after the first valid instruction:
- inst_out=15, pc_out=0 held for 3 cycles, PC=4 held; then flow resumes with no instruction lost or duplicated.
REQ-035 branch_en=1, target=0x8, while pc_out=0x4 is valid and inst_ready=0:
- inst_valid=0 next cycle; the next presented instruction is 23 at pc_out=8.
REQ-036 In HALT (PC=0x10), branch_en=1, target=0x0: -> RUN, and 15 is re-fetched at pc_out=0.
REQ-037 branch_en=1, target=0x6: fault=1, inst_valid=0, stays in FAULT through start pulses until rst.
REQ-038 rst asserted asynchronously between clock edges during RUN: all outputs take their reset values immediately, before the next edge.

Source files
------------

// File: rtl/fetch_controller.sv
// Instruction fetch controller: walks a PC through a combinational instruction
// memory, presents one registered instruction at a time and handles redirects.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] LAST_ADDR = 32'h0000_001C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] inst_out,
    output logic [31:0] pc_out,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        branch_en,
    input  logic [31:0] branch_target,
    output logic        halted,
    output logic        fault,
    output logic [15:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t      state_r;
    logic [31:0] pc_r;

    logic accepted_s;
    logic slot_free_s;
    logic redirect_s;
    logic branch_ok_s;
    logic branch_bad_s;
    logic past_end_s;
    logic zero_word_s;

    function automatic logic [15:0] sat_inc(input logic [15:0] count);
        if (count == 16'hFFFF) begin
            sat_inc = count;
        end else begin
            sat_inc = count + 16'd1;
        end
    endfunction

    function automatic logic word_aligned(input logic [31:0] addr);
        word_aligned = (addr[1:0] == 2'b00);
    endfunction

    assign imem_addr = pc_r;

    // Handshake and redirect decode shared by the state machine.
    always_comb begin
        accepted_s   = inst_valid & inst_ready;
        slot_free_s  = ~inst_valid | inst_ready;
        past_end_s   = (pc_r > LAST_ADDR);
        zero_word_s  = (imem_data == 32'h0000_0000);
        if ((state_r == ST_RUN) || (state_r == ST_HALT)) begin
            redirect_s = branch_en;
        end else begin
            redirect_s = 1'b0;
        end
        branch_ok_s  = redirect_s & word_aligned(branch_target);
        branch_bad_s = redirect_s & ~word_aligned(branch_target);
    end

    // Fetch state machine with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_PC;
            inst_out    <= 32'h0000_0000;
            pc_out      <= 32'h0000_0000;
            inst_valid  <= 1'b0;
            halted      <= 1'b0;
            fault       <= 1'b0;
            fetch_count <= 16'h0000;
        end else begin
            // Acceptance is counted whatever else happens in the same cycle.
            if (accepted_s) begin
                fetch_count <= sat_inc(fetch_count);
            end else begin
                fetch_count <= fetch_count;
            end

            if (branch_ok_s) begin
                state_r    <= ST_RUN;
                pc_r       <= branch_target;
                inst_valid <= 1'b0;
                halted     <= 1'b0;
            end else if (branch_bad_s) begin
                state_r    <= ST_FAULT;
                inst_valid <= 1'b0;
                halted     <= 1'b0;
                fault      <= 1'b1;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            state_r <= ST_RUN;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (!slot_free_s) begin
                            state_r <= ST_RUN;
                        end else if (past_end_s || zero_word_s) begin
                            // PC stays on the terminating address for inspection.
                            state_r    <= ST_HALT;
                            inst_valid <= 1'b0;
                            halted     <= 1'b1;
                        end else begin
                            inst_out   <= imem_data;
                            pc_out     <= pc_r;
                            inst_valid <= 1'b1;
                            pc_r       <= pc_r + 32'd4;
                        end
                    end
                    ST_HALT: begin
                        state_r <= ST_HALT;
                        halted  <= 1'b1;
                    end
                    ST_FAULT: begin
                        state_r <= ST_FAULT;
                        fault   <= 1'b1;
                    end
                    default: begin
                        state_r    <= ST_FAULT;
                        inst_valid <= 1'b0;
                        fault      <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed self-checking bench for fetch_controller with a small behavioural
// instruction memory and hand-computed expectations.
module tb_fetch_controller;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic        inst_valid;
    logic        inst_ready;
    logic        branch_en;
    logic [31:0] branch_target;
    logic        halted;
    logic        fault;
    logic [15:0] fetch_count;

    int vectors;
    int miscompares;

    logic [31:0] mem [0:15];
    logic [31:0] exp_words [0:7];
    logic [31:0] exp_pcs   [0:7];

    fetch_controller #(.RESET_PC(32'h0), .LAST_ADDR(32'h1C)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .inst_out(inst_out), .pc_out(pc_out), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .branch_en(branch_en), .branch_target(branch_target),
        .halted(halted), .fault(fault), .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Addresses beyond the array return a non-zero poison word.
    assign imem_data = (imem_addr[31:6] == 26'd0) ? mem[imem_addr[5:2]] : 32'hFFFF_FFFF;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem;
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'd15; mem[1] = 32'd61; mem[2] = 32'd23; mem[3] = 32'd81;
        mem[8] = 32'h0000_00EE;
        exp_words[0] = 32'd15; exp_words[1] = 32'd61; exp_words[2] = 32'd23; exp_words[3] = 32'd81;
        exp_words[4] = 32'hAA; exp_words[5] = 32'hBB; exp_words[6] = 32'hCC; exp_words[7] = 32'hDD;
        for (int i = 0; i < 8; i++) exp_pcs[i] = 32'd4 * i;
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; branch_en = 1'b0; branch_target = 32'h0; inst_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        vectors++; if ({inst_valid, halted, fault, fetch_count} !== 19'h0) begin miscompares++; $display("FAIL reset_flags got %h exp %h", {inst_valid, halted, fault, fetch_count}, 19'h0); end
        vectors++; if ({inst_out, pc_out, imem_addr} !== 96'h0) begin miscompares++; $display("FAIL reset_regs got %h exp %h", {inst_out, pc_out, imem_addr}, 96'h0); end
        // A redirect while idle must be ignored.
        branch_en = 1'b1; branch_target = 32'h8;
        tick;
        branch_en = 1'b0;
        vectors++; if ({inst_valid, imem_addr} !== {1'b0, 32'h0}) begin miscompares++; $display("FAIL idle_branch got %h exp %h", {inst_valid, imem_addr}, {1'b0, 32'h0}); end
        pulse_start;
        tick;
        vectors++; if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'h0, 32'd15}) begin miscompares++; $display("FAIL idle_branch_first got %h exp %h", {inst_valid, pc_out, inst_out}, {1'b1, 32'h0, 32'd15}); end
    endtask

    task automatic test_basic;
        do_reset;
        pulse_start;
        vectors++; if (inst_valid !== 1'b0) begin miscompares++; $display("FAIL basic_no_early_fetch got %b exp %b", inst_valid, 1'b0); end
        for (int i = 0; i < 4; i++) begin
            tick;
            vectors++; if ({inst_valid, pc_out, inst_out} !== {1'b1, exp_pcs[i], exp_words[i]}) begin miscompares++; $display("FAIL basic_seq%0d got %h exp %h", i, {inst_valid, pc_out, inst_out}, {1'b1, exp_pcs[i], exp_words[i]}); end
        end
        tick;
        vectors++; if ({inst_valid, halted, imem_addr, fetch_count} !== {1'b0, 1'b1, 32'h10, 16'd4}) begin miscompares++; $display("FAIL basic_halt got %h exp %h", {inst_valid, halted, imem_addr, fetch_count}, {1'b0, 1'b1, 32'h10, 16'd4}); end
    endtask

    task automatic test_stall;
        do_reset;
        inst_ready = 1'b0;
        pulse_start;
        tick;
        for (int i = 0; i < 3; i++) begin
            vectors++; if ({inst_valid, pc_out, inst_out, imem_addr} !== {1'b1, 32'h0, 32'd15, 32'h4}) begin miscompares++; $display("FAIL stall_hold%0d got %h exp %h", i, {inst_valid, pc_out, inst_out, imem_addr}, {1'b1, 32'h0, 32'd15, 32'h4}); end
            tick;
        end
        inst_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick;
            vectors++; if ({inst_valid, pc_out, inst_out} !== {1'b1, exp_pcs[i], exp_words[i]}) begin miscompares++; $display("FAIL stall_resume%0d got %h exp %h", i, {inst_valid, pc_out, inst_out}, {1'b1, exp_pcs[i], exp_words[i]}); end
        end
        tick;
        vectors++; if ({halted, fetch_count} !== {1'b1, 16'd4}) begin miscompares++; $display("FAIL stall_count got %h exp %h", {halted, fetch_count}, {1'b1, 16'd4}); end
    endtask

    task automatic test_branch;
        do_reset;
        pulse_start;
        tick;
        tick;
        vectors++; if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'h4, 32'd61}) begin miscompares++; $display("FAIL branch_pre got %h exp %h", {inst_valid, pc_out, inst_out}, {1'b1, 32'h4, 32'd61}); end
        inst_ready = 1'b0; branch_en = 1'b1; branch_target = 32'h8;
        tick;
        branch_en = 1'b0; inst_ready = 1'b1;
        vectors++; if ({inst_valid, imem_addr, fetch_count} !== {1'b0, 32'h8, 16'd1}) begin miscompares++; $display("FAIL branch_flush got %h exp %h", {inst_valid, imem_addr, fetch_count}, {1'b0, 32'h8, 16'd1}); end
        tick;
        vectors++; if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'h8, 32'd23}) begin miscompares++; $display("FAIL branch_target got %h exp %h", {inst_valid, pc_out, inst_out}, {1'b1, 32'h8, 32'd23}); end
        // Redirect in the same cycle as an acceptance still counts it.
        branch_en = 1'b1; branch_target = 32'h0;
        tick;
        branch_en = 1'b0;
        vectors++; if ({inst_valid, imem_addr, fetch_count} !== {1'b0, 32'h0, 16'd2}) begin miscompares++; $display("FAIL branch_accept got %h exp %h", {inst_valid, imem_addr, fetch_count}, {1'b0, 32'h0, 16'd2}); end
        tick;
        vectors++; if ({inst_valid, pc_out, inst_out} !== {1'b1, 32'h0, 32'd15}) begin miscompares++; $display("FAIL branch_refetch got %h exp %h", {inst_valid, pc_out, inst_out}, {1'b1, 32'h0, 32'd15}); end
    endtask

    task automatic test_halt_branch;
        do_reset;
        pulse_start;
        for (int i = 0; i < 6; i++) tick;
        vectors++; if ({inst_valid, halted, imem_addr, fetch_count} !== {1'b0, 1'b1, 32'h10, 16'd4}) begin miscompares++; $display("FAIL halt_hold got %h exp %h", {inst_valid, halted, imem_addr, fetch_count}, {1'b0, 1'b1, 32'h10, 16'd4}); end
        branch_en = 1'b1; branch_target = 32'h0;
        tick;
        branch_en = 1'b0;
        vectors++; if ({inst_valid, halted, imem_addr} !== {1'b0, 1'b0, 32'h0}) begin miscompares++; $display("FAIL halt_branch got %h exp %h", {inst_valid, halted, imem_addr}, {1'b0, 1'b0, 32'h0}); end
        tick;
        vectors++; if ({inst_valid, pc_out, inst_out, fetch_count} !== {1'b1, 32'h0, 32'd15, 16'd4}) begin miscompares++; $display("FAIL halt_refetch got %h exp %h", {inst_valid, pc_out, inst_out, fetch_count}, {1'b1, 32'h0, 32'd15, 16'd4}); end
    endtask

    task automatic test_last_addr;
        mem[4] = 32'hAA; mem[5] = 32'hBB; mem[6] = 32'hCC; mem[7] = 32'hDD;
        do_reset;
        pulse_start;
        for (int i = 0; i < 8; i++) begin
            tick;
            vectors++; if ({inst_valid, pc_out, inst_out} !== {1'b1, exp_pcs[i], exp_words[i]}) begin miscompares++; $display("FAIL last_seq%0d got %h exp %h", i, {inst_valid, pc_out, inst_out}, {1'b1, exp_pcs[i], exp_words[i]}); end
        end
        tick;
        vectors++; if ({inst_valid, halted, imem_addr, fetch_count} !== {1'b0, 1'b1, 32'h20, 16'd8}) begin miscompares++; $display("FAIL last_halt got %h exp %h", {inst_valid, halted, imem_addr, fetch_count}, {1'b0, 1'b1, 32'h20, 16'd8}); end
        load_mem;
    endtask

    task automatic test_fault;
        do_reset;
        pulse_start;
        tick;
        branch_en = 1'b1; branch_target = 32'h6;
        tick;
        branch_en = 1'b0;
        vectors++; if ({fault, inst_valid, halted, imem_addr} !== {1'b1, 1'b0, 1'b0, 32'h4}) begin miscompares++; $display("FAIL fault_enter got %h exp %h", {fault, inst_valid, halted, imem_addr}, {1'b1, 1'b0, 1'b0, 32'h4}); end
        pulse_start;
        branch_en = 1'b1; branch_target = 32'h0;
        tick;
        branch_en = 1'b0;
        tick;
        vectors++; if ({fault, inst_valid, imem_addr} !== {1'b1, 1'b0, 32'h4}) begin miscompares++; $display("FAIL fault_sticky got %h exp %h", {fault, inst_valid, imem_addr}, {1'b1, 1'b0, 32'h4}); end
        do_reset;
        vectors++; if ({fault, imem_addr} !== {1'b0, 32'h0}) begin miscompares++; $display("FAIL fault_clear got %h exp %h", {fault, imem_addr}, {1'b0, 32'h0}); end
    endtask

    task automatic test_async_reset;
        do_reset;
        pulse_start;
        tick;
        tick;
        inst_ready = 1'b0;
        tick;
        vectors++; if ({inst_valid, pc_out, fetch_count} !== {1'b1, 32'h4, 16'd1}) begin miscompares++; $display("FAIL async_pre got %h exp %h", {inst_valid, pc_out, fetch_count}, {1'b1, 32'h4, 16'd1}); end
        #3;
        rst = 1'b1;
        #1;
        vectors++; if ({inst_valid, inst_out, pc_out, imem_addr, fetch_count, halted, fault} !== 115'h0) begin miscompares++; $display("FAIL async_reset got %h exp %h", {inst_valid, inst_out, pc_out, imem_addr, fetch_count, halted, fault}, 115'h0); end
        #2;
        rst = 1'b0;
        inst_ready = 1'b1;
        pulse_start;
        tick;
        vectors++; if ({inst_valid, pc_out, inst_out, fetch_count} !== {1'b1, 32'h0, 32'd15, 16'd0}) begin miscompares++; $display("FAIL async_restart got %h exp %h", {inst_valid, pc_out, inst_out, fetch_count}, {1'b1, 32'h0, 32'd15, 16'd0}); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1; start = 1'b0; branch_en = 1'b0; branch_target = 32'h0; inst_ready = 1'b1;
        load_mem;
        test_reset;
        test_basic;
        test_stall;
        test_branch;
        test_halt_branch;
        test_last_addr;
        test_fault;
        test_async_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
